multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4 (legal 1..16), meaning the number of EXEC cycles for the MULT funct.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 0 (legal 0..255), meaning the maximum number of wait cycles for ihit/dhit; 0 disables the timeout.
REQ-003 SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port instr, input, 32 bits: instruction word from memory, valid when ihit=1.
REQ-006 SHALL have ports ihit and dhit, input, 1 bit each: instruction and data memory acknowledge.
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag, sampled in EXEC.
REQ-008 SHALL have ports iread, dread and dwrite, output, 1 bit each: memory requests to the request unit.
REQ-009 SHALL have ports IRWr, PCWr, RegWr, ALUSrc, MemtoReg and ExtOp, output, 1 bit each: datapath enables and selects.
REQ-010 SHALL have ports RegDst and PCSrc, output, 2 bits each. RegDst: 0=rt, 1=rd, 2=$31. PCSrc: 0=PC+4, 1=branch, 2=jump, 3=register.
REQ-011 SHALL have port ALUCtr, output, 4 bits. Encoding: SLL=0, SRL=1, ADD=2, SUB=3, AND=4, OR=5, XOR=6, NOR=7, SLT=8, SLTU=9, MUL=10.
REQ-012 SHALL have ports halt and buserr, output, 1 bit each.
REQ-013 SHALL have port state, output, 3 bits: current FSM state, for debug.

Function
REQ-014 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 go to HALT with buserr=1.
REQ-015 FETCH: iread=1 until ihit=1. On ihit, IRWr=1 and PCWr=1 (PCSrc=0) for exactly that cycle, then go to DECODE.
REQ-016 DECODE: one cycle; latch the opcode/funct-derived control word into registers. Opcode 111111 goes to HALT; all others go to EXEC.
REQ-017 EXEC: ALUCtr and ALUSrc driven from the latched control word for every EXEC cycle.
REQ-018 EXEC for MULT (R-type, funct 011000) SHALL last exactly MUL_LAT cycles, counted by an internal down-counter. All other ops take 1 cycle.
REQ-019 BEQ/BNE in EXEC: PCWr=1 with PCSrc=1 iff zero (BEQ) or !zero (BNE), in the final EXEC cycle, then go to FETCH.
REQ-020 J in EXEC: PCWr=1, PCSrc=2, then go to FETCH.
REQ-021 JAL in EXEC: PCWr=1, PCSrc=2, RegWr=1, RegDst=2, then go to FETCH.
REQ-022 JR in EXEC: PCWr=1, PCSrc=3, then go to FETCH.
REQ-023 LW/SW go from EXEC to MEM; all other ops go to WB.
REQ-024 MEM: dread=1 (LW) or dwrite=1 (SW), held stable until dhit=1. LW then goes to WB; SW goes to FETCH.
REQ-025 WB: RegWr=1 for exactly one cycle, then go to FETCH. MemtoReg=1 only for LW; RegDst=1 for R-type, 0 for I-type.
REQ-026 ExtOp=1 (sign-extend) for ADDIU, SLTI, LW, SW, BEQ and BNE; ExtOp=0 for ANDI, ORI, XORI and LUI.
REQ-027 An unknown opcode or funct SHALL go to HALT with buserr=1. No RegWr or PCWr is asserted for that instruction.
REQ-028 Every output not named active for a state SHALL be 0 in that state.
REQ-029 iread, dread and dwrite SHALL be mutually exclusive in every cycle.
REQ-030 Timeout (MEM_TIMEOUT>0): a wait counter clears on state entry and increments each cycle that ihit/dhit is 0. When it reaches MEM_TIMEOUT, go to HALT with buserr=1.
REQ-031 An ihit or dhit arriving in the same cycle as the timeout SHALL win; the access completes normally.
REQ-032 HALT is absorbing: halt=1 and all requests and write enables are 0 until RST.
REQ-033 ihit outside FETCH and dhit outside MEM SHALL be ignored.

Reset
REQ-034 RST=1 at a clock edge SHALL set state=FETCH, clear the latched control word, MUL counter, wait counter and buserr, and force halt=0.
REQ-035 RST SHALL take priority over every transition, including mid-MULT, mid-MEM wait and HALT.
REQ-036 In the cycle after RST deasserts, iread=1.

Verification
REQ-037 ADDU $3,$1,$2 (instr 0x00221821), ihit in cycle 1 -> DECODE, EXEC (ALUCtr=2), WB (RegWr=1, RegDst=1); back in FETCH 4 cycles after ihit.
REQ-038 MUL_LAT=4, MULT instr -> EXEC held exactly 4 cycles with ALUCtr=10, then WB.
REQ-039 LW with dhit delayed 3 cycles -> dread=1 held for 4 cycles, then WB with MemtoReg=1 and RegWr=1.
REQ-040 BEQ with zero=1 -> PCWr=1, PCSrc=1 in EXEC. Same instr with zero=0 -> PCWr=0; next state is FETCH in both cases.
REQ-041 MEM_TIMEOUT=5, ihit never asserted -> HALT after 5 wait cycles with buserr=1 and halt=1. Repeat with ihit in cycle 5 -> normal DECODE.
REQ-042 Opcode 0x3F -> HALT after DECODE with halt=1 and buserr=0. RST asserted in HALT -> state=FETCH and halt=0 on the next edge.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Ports: CLK/RST (sync, active-high), instr/ihit/dhit/zero in;
//   memory requests, datapath enables/selects, halt/buserr, state out.
module multicycle_control_unit #(
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] instr,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        zero,
  output logic        iread,
  output logic        dread,
  output logic        dwrite,
  output logic        IRWr,
  output logic        PCWr,
  output logic        RegWr,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        ExtOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  PCSrc,
  output logic [3:0]  ALUCtr,
  output logic        halt,
  output logic        buserr,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_ALU,
    K_MULT,
    K_BEQ,
    K_BNE,
    K_J,
    K_JAL,
    K_JR,
    K_LW,
    K_SW,
    K_STOP,
    K_BAD
  } kind_t;

  localparam logic [3:0] A_SLL  = 4'd0;
  localparam logic [3:0] A_SRL  = 4'd1;
  localparam logic [3:0] A_ADD  = 4'd2;
  localparam logic [3:0] A_SUB  = 4'd3;
  localparam logic [3:0] A_AND  = 4'd4;
  localparam logic [3:0] A_OR   = 4'd5;
  localparam logic [3:0] A_XOR  = 4'd6;
  localparam logic [3:0] A_NOR  = 4'd7;
  localparam logic [3:0] A_SLT  = 4'd8;
  localparam logic [3:0] A_SLTU = 4'd9;
  localparam logic [3:0] A_MUL  = 4'd10;

  localparam logic [3:0] MUL_LD = 4'(MUL_LAT - 1);
  localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);

  state_t     st;
  state_t     st_n;
  logic       berr;
  logic       berr_n;

  // opcode/funct captured when the fetch completes
  logic [5:0] ir_op;
  logic [5:0] ir_fn;

  // latched control word
  kind_t      cw_kind;
  logic [3:0] cw_alu;
  logic       cw_src;
  logic       cw_ext;
  logic       cw_rdst;
  logic       cw_m2r;

  logic [3:0] mcnt;
  logic [7:0] wcnt;

  kind_t      d_kind;
  logic [3:0] d_alu;
  logic       d_src;
  logic       d_ext;
  logic       d_rdst;
  logic       d_m2r;

  logic       tmo;
  logic       unused_ok;

  assign unused_ok = ^instr[25:6];
  assign state     = st;
  assign buserr    = berr;

  // fires on the last allowed wait cycle; a hit that cycle wins
  assign tmo = (TMO != 8'd0) && (wcnt + 8'd1 == TMO);

  always_comb begin
    d_kind = K_BAD;
    d_alu  = A_SLL;
    d_src  = 1'b0;
    d_ext  = 1'b0;
    d_rdst = 1'b0;
    d_m2r  = 1'b0;
    unique case (ir_op)
      6'h00: begin
        d_kind = K_ALU;
        d_rdst = 1'b1;
        unique case (ir_fn)
          6'h00: d_alu = A_SLL;
          6'h02: d_alu = A_SRL;
          6'h08: d_kind = K_JR;
          6'h18: begin
            d_kind = K_MULT;
            d_alu  = A_MUL;
          end
          6'h20, 6'h21: d_alu = A_ADD;
          6'h22, 6'h23: d_alu = A_SUB;
          6'h24: d_alu = A_AND;
          6'h25: d_alu = A_OR;
          6'h26: d_alu = A_XOR;
          6'h27: d_alu = A_NOR;
          6'h2a: d_alu = A_SLT;
          6'h2b: d_alu = A_SLTU;
          default: d_kind = K_BAD;
        endcase
      end
      6'h02: d_kind = K_J;
      6'h03: d_kind = K_JAL;
      6'h04: begin
        d_kind = K_BEQ;
        d_alu  = A_SUB;
        d_ext  = 1'b1;
      end
      6'h05: begin
        d_kind = K_BNE;
        d_alu  = A_SUB;
        d_ext  = 1'b1;
      end
      6'h09: begin
        d_kind = K_ALU;
        d_alu  = A_ADD;
        d_src  = 1'b1;
        d_ext  = 1'b1;
      end
      6'h0a: begin
        d_kind = K_ALU;
        d_alu  = A_SLT;
        d_src  = 1'b1;
        d_ext  = 1'b1;
      end
      6'h0c: begin
        d_kind = K_ALU;
        d_alu  = A_AND;
        d_src  = 1'b1;
      end
      6'h0d: begin
        d_kind = K_ALU;
        d_alu  = A_OR;
        d_src  = 1'b1;
      end
      6'h0e: begin
        d_kind = K_ALU;
        d_alu  = A_XOR;
        d_src  = 1'b1;
      end
      // LUI: the ALU shifts the zero-extended immediate
      6'h0f: begin
        d_kind = K_ALU;
        d_alu  = A_SLL;
        d_src  = 1'b1;
      end
      6'h23: begin
        d_kind = K_LW;
        d_alu  = A_ADD;
        d_src  = 1'b1;
        d_ext  = 1'b1;
        d_m2r  = 1'b1;
      end
      6'h2b: begin
        d_kind = K_SW;
        d_alu  = A_ADD;
        d_src  = 1'b1;
        d_ext  = 1'b1;
      end
      6'h3f: d_kind = K_STOP;
      default: d_kind = K_BAD;
    endcase
  end

  always_comb begin
    st_n     = st;
    berr_n   = berr;
    iread    = 1'b0;
    dread    = 1'b0;
    dwrite   = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    RegWr    = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    ExtOp    = 1'b0;
    RegDst   = 2'd0;
    PCSrc    = 2'd0;
    ALUCtr   = 4'd0;
    halt     = 1'b0;
    unique case (st)
      FETCH: begin
        iread = 1'b1;
        if (ihit) begin
          IRWr = 1'b1;
          PCWr = 1'b1;
          st_n = DECODE;
        end else if (tmo) begin
          st_n   = HALT;
          berr_n = 1'b1;
        end
      end
      DECODE: begin
        unique case (d_kind)
          K_STOP: st_n = HALT;
          K_BAD: begin
            st_n   = HALT;
            berr_n = 1'b1;
          end
          default: st_n = EXEC;
        endcase
      end
      EXEC: begin
        ALUCtr = cw_alu;
        ALUSrc = cw_src;
        ExtOp  = cw_ext;
        if (mcnt == 4'd0) begin
          unique case (cw_kind)
            K_BEQ: begin
              PCWr  = zero;
              PCSrc = zero ? 2'd1 : 2'd0;
              st_n  = FETCH;
            end
            K_BNE: begin
              PCWr  = !zero;
              PCSrc = !zero ? 2'd1 : 2'd0;
              st_n  = FETCH;
            end
            K_J: begin
              PCWr  = 1'b1;
              PCSrc = 2'd2;
              st_n  = FETCH;
            end
            K_JAL: begin
              PCWr   = 1'b1;
              PCSrc  = 2'd2;
              RegWr  = 1'b1;
              RegDst = 2'd2;
              st_n   = FETCH;
            end
            K_JR: begin
              PCWr  = 1'b1;
              PCSrc = 2'd3;
              st_n  = FETCH;
            end
            K_LW, K_SW: st_n = MEM;
            default: st_n = WB;
          endcase
        end
      end
      MEM: begin
        dread  = (cw_kind == K_LW);
        dwrite = (cw_kind == K_SW);
        if (dhit) begin
          st_n = (cw_kind == K_LW) ? WB : FETCH;
        end else if (tmo) begin
          st_n   = HALT;
          berr_n = 1'b1;
        end
      end
      WB: begin
        RegWr    = 1'b1;
        MemtoReg = cw_m2r;
        RegDst   = {1'b0, cw_rdst};
        st_n     = FETCH;
      end
      HALT: halt = 1'b1;
      default: begin
        st_n   = HALT;
        berr_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st      <= FETCH;
      berr    <= 1'b0;
      ir_op   <= 6'd0;
      ir_fn   <= 6'd0;
      cw_kind <= K_ALU;
      cw_alu  <= 4'd0;
      cw_src  <= 1'b0;
      cw_ext  <= 1'b0;
      cw_rdst <= 1'b0;
      cw_m2r  <= 1'b0;
      mcnt    <= 4'd0;
      wcnt    <= 8'd0;
    end else begin
      st   <= st_n;
      berr <= berr_n;
      if (st == FETCH && ihit) begin
        ir_op <= instr[31:26];
        ir_fn <= instr[5:0];
      end
      if (st == DECODE) begin
        cw_kind <= d_kind;
        cw_alu  <= d_alu;
        cw_src  <= d_src;
        cw_ext  <= d_ext;
        cw_rdst <= d_rdst;
        cw_m2r  <= d_m2r;
        mcnt    <= (d_kind == K_MULT) ? MUL_LD : 4'd0;
      end else if (st == EXEC && mcnt != 4'd0) begin
        mcnt <= mcnt - 4'd1;
      end
      if (st_n != st) begin
        wcnt <= 8'd0;
      end else if ((st == FETCH && !ihit) ||
                   (st == MEM && !dhit)) begin
        wcnt <= wcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MUL_LAT=4, MEM_TIMEOUT=5).
// Compares the full output vector against hand-computed values.
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] instr;
  logic        ihit, dhit, zero;
  logic        iread, dread, dwrite;
  logic        IRWr, PCWr, RegWr, ALUSrc, MemtoReg, ExtOp;
  logic [1:0]  RegDst, PCSrc;
  logic [3:0]  ALUCtr;
  logic        halt, buserr;
  logic [2:0]  state;

  int ntest = 0;
  int nfail = 0;

  multicycle_control_unit #(.MUL_LAT(4), .MEM_TIMEOUT(5)) dut (
    .CLK(CLK), .RST(RST), .instr(instr),
    .ihit(ihit), .dhit(dhit), .zero(zero),
    .iread(iread), .dread(dread), .dwrite(dwrite),
    .IRWr(IRWr), .PCWr(PCWr), .RegWr(RegWr),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
    .RegDst(RegDst), .PCSrc(PCSrc), .ALUCtr(ALUCtr),
    .halt(halt), .buserr(buserr), .state(state)
  );

  always #5 CLK = ~CLK;

  // {state, iread,dread,dwrite,IRWr,PCWr,RegWr,ALUSrc,MemtoReg,ExtOp,
  //  RegDst, PCSrc, ALUCtr, halt, buserr}
  logic [21:0] obs;
  assign obs = {state, iread, dread, dwrite, IRWr, PCWr, RegWr,
                ALUSrc, MemtoReg, ExtOp, RegDst, PCSrc, ALUCtr,
                halt, buserr};

  function automatic logic [21:0] ev(
    input logic [2:0] s, input logic [8:0] f,
    input logic [1:0] rd, input logic [1:0] pcs,
    input logic [3:0] alu, input logic h, input logic be);
    return {s, f, rd, pcs, alu, h, be};
  endfunction

  task automatic chk(input string tag, input logic [21:0] e);
    ntest++;
    assert (obs === e) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic drive(input logic ih, input logic dh,
                       input logic z, input logic [31:0] ins);
    ihit = ih; dhit = dh; zero = z; instr = ins;
    #1;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    adv();
    RST = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ins);
    drive(1'b1, 1'b0, 1'b0, ins);
    chk({tag, "_if"}, ev(3'd0, 9'b100110000, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk({tag, "_id"}, ev(3'd1, 9'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
  endtask

  localparam logic [21:0] E_FI  = 22'({3'd0, 9'b100000000, 10'd0});
  localparam logic [21:0] E_RHB = 22'({3'd5, 9'b0, 8'd0, 2'b11});
  localparam logic [21:0] E_RHN = 22'({3'd5, 9'b0, 8'd0, 2'b10});

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    adv();
    adv();
    chk("reset", E_FI);
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_reset", E_FI);

    // ADDU $3,$1,$2
    fetch("addu", 32'h00221821);
    chk("addu_ex", ev(3'd2, 9'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0));
    adv();
    chk("addu_wb", ev(3'd4, 9'b000001000, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
    chk("addu_done", E_FI);

    // MULT $1,$2 : four EXEC cycles
    fetch("mult", 32'h00220018);
    for (int i = 0; i < 4; i++) begin
      chk("mult_ex", ev(3'd2, 9'b0, 2'd0, 2'd0, 4'd10, 1'b0, 1'b0));
      adv();
    end
    chk("mult_wb", ev(3'd4, 9'b000001000, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
    chk("mult_done", E_FI);

    // LW $2,4($1) with dhit after 3 wait cycles
    fetch("lw", 32'h8C220004);
    chk("lw_ex", ev(3'd2, 9'b000000101, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0));
    adv();
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_wait", ev(3'd3, 9'b010000000, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
      adv();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("lw_mem_hit", ev(3'd3, 9'b010000000, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("lw_wb", ev(3'd4, 9'b000001010, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
    chk("lw_done", E_FI);

    // BEQ taken then not taken
    fetch("beq1", 32'h10220003);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    chk("beq_taken", ev(3'd2, 9'b000010001, 2'd0, 2'd1, 4'd3, 1'b0, 1'b0));
    adv();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("beq1_next", E_FI);
    fetch("beq0", 32'h10220003);
    chk("beq_not", ev(3'd2, 9'b000000001, 2'd0, 2'd0, 4'd3, 1'b0, 1'b0));
    adv();
    chk("beq0_next", E_FI);

    // JAL
    fetch("jal", 32'h0C000010);
    chk("jal_ex", ev(3'd2, 9'b000011000, 2'd2, 2'd2, 4'd0, 1'b0, 1'b0));
    adv();
    chk("jal_next", E_FI);

    // SW with immediate dhit
    fetch("sw", 32'hAC220008);
    chk("sw_ex", ev(3'd2, 9'b000000101, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0));
    adv();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("sw_mem", ev(3'd3, 9'b001000000, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("sw_next", E_FI);

    // ORI with stray ihit/dhit during EXEC and WB
    fetch("ori", 32'h34220005);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("ori_ex", ev(3'd2, 9'b000000100, 2'd0, 2'd0, 4'd5, 1'b0, 1'b0));
    adv();
    chk("ori_wb", ev(3'd4, 9'b000001000, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    adv();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ori_next", E_FI);

    // JR $31
    fetch("jr", 32'h03E00008);
    chk("jr_ex", ev(3'd2, 9'b000010000, 2'd0, 2'd3, 4'd0, 1'b0, 1'b0));
    adv();
    chk("jr_next", E_FI);

    // fetch timeout: five idle cycles then HALT with buserr
    for (int i = 0; i < 5; i++) begin
      chk("tmo_wait", E_FI);
      adv();
    end
    chk("tmo_halt", E_RHB);
    drive(1'b1, 1'b1, 1'b0, 32'h00221821);
    adv();
    chk("tmo_absorb", E_RHB);
    do_reset();
    chk("tmo_reset", E_FI);

    // ihit on the fifth cycle wins over the timeout
    for (int i = 0; i < 4; i++) begin
      chk("late_wait", E_FI);
      adv();
    end
    fetch("late", 32'h00221821);
    chk("late_ex", ev(3'd2, 9'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0));
    adv();
    adv();
    chk("late_done", E_FI);

    // MEM timeout on LW
    fetch("lwt", 32'h8C220004);
    adv();
    for (int i = 0; i < 5; i++) begin
      chk("lwt_wait", ev(3'd3, 9'b010000000, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
      adv();
    end
    chk("lwt_halt", E_RHB);
    do_reset();

    // unknown opcode and unknown funct
    fetch("badop", 32'hF8000000);
    chk("badop_halt", E_RHB);
    do_reset();
    fetch("badfn", 32'h00000001);
    chk("badfn_halt", E_RHB);
    do_reset();

    // HALT opcode then reset out of HALT
    fetch("stop", 32'hFC000000);
    chk("stop_halt", E_RHN);
    adv();
    chk("stop_absorb", E_RHN);
    do_reset();
    chk("stop_reset", E_FI);

    // reset in the middle of MULT
    fetch("mrst", 32'h00220018);
    adv();
    chk("mrst_ex", ev(3'd2, 9'b0, 2'd0, 2'd0, 4'd10, 1'b0, 1'b0));
    do_reset();
    chk("mrst_reset", E_FI);
    fetch("after", 32'h00221821);
    chk("after_ex", ev(3'd2, 9'b0, 2'd0, 2'd0, 4'd2, 1'b0, 1'b0));
    adv();
    chk("after_wb", ev(3'd4, 9'b000001000, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
